writeback_23rv: RTL and testbench

Writeback stage of the 23RV core and sole driver of the register-file write port (rd/wd/we). Merges single-cycle ALU results with backpressured load/long-latency results through a small FIFO, and keeps a per-register pending scoreboard that the hazard logic queries before issuing. Outputs are registered and connect directly to the register file's write inputs.

---
 rtl/writeback_23rv_pkg.sv | 18 +
 rtl/wb_fifo_23rv.sv | 65 ++++++
 rtl/writeback_23rv.sv | 143 ++++++++++++++
 tb/tb_writeback_23rv.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_23rv_pkg.sv
// writeback_23rv_pkg
// Shared definitions for the 23RV writeback stage.
//   DEF_ADDRESS_BITWIDTH : default register index width
//   DEF_DATA_WIDTH       : default result data width
//   DEF_NREGS            : register count implied by the default index width
//   wb_entry_t           : one buffered LSU result {rd, data}
package writeback_23rv_pkg;

    localparam int DEF_ADDRESS_BITWIDTH = 5;
    localparam int DEF_DATA_WIDTH       = 32;
    localparam int DEF_NREGS            = 1 << DEF_ADDRESS_BITWIDTH;

    typedef struct packed {
        logic [DEF_ADDRESS_BITWIDTH-1:0] rd;
        logic [DEF_DATA_WIDTH-1:0]       data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo_23rv.sv
// wb_fifo_23rv
// Small circular FIFO buffering LSU results ahead of the writeback arbiter.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   push, wdata     : write request and data (ignored when full)
//   pop, rdata      : read request (ignored when empty); rdata shows the head
//   full, empty     : occupancy flags
//   count           : number of valid entries, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module wb_fifo_23rv #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // observed after a push has written it, and leaving it out of reset lets
    // it map onto plain flops or LUT RAM without a reset network.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/writeback_23rv.sv
// writeback_23rv
// Writeback stage of the 23RV core; sole driver of the register-file write
// port. ALU results (no backpressure) always win arbitration; LSU results are
// buffered in wb_fifo_23rv and drained when the ALU is idle. A per-register
// pending scoreboard tracks outstanding long-latency results for hazard logic.
// Ports:
//   clk, reset                       : clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data        : single-cycle ALU result
//   lsu_valid/lsu_ready/lsu_rd/lsu_data : backpressured LSU result
//   issue_valid/issue_rd             : long-latency issue, marks rd pending
//   rs1, rs2                         : decode source indices
//   rs1_pending, rs2_pending         : source awaits an LSU result (comb.)
//   rs1_byp, rs2_byp, rsN_byp_data   : bypass from the write in progress
//   rf_we, rf_rd, rf_wd              : registered register-file write port
// Configuration: define WB_BYPASS_EN to enable the rf_* -> rsN bypass;
// otherwise the bypass outputs are tied to zero.
// ADDRESS_BITWIDTH/DATA_WIDTH must match the widths of wb_entry_t in the package.
module writeback_23rv
    import writeback_23rv_pkg::*;
#(
    parameter int ADDRESS_BITWIDTH = DEF_ADDRESS_BITWIDTH,
    parameter int DATA_WIDTH       = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        alu_valid,
    input  logic [ADDRESS_BITWIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]       alu_data,
    input  logic                        lsu_valid,
    output logic                        lsu_ready,
    input  logic [ADDRESS_BITWIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0]       lsu_data,
    input  logic                        issue_valid,
    input  logic [ADDRESS_BITWIDTH-1:0] issue_rd,
    input  logic [ADDRESS_BITWIDTH-1:0] rs1,
    input  logic [ADDRESS_BITWIDTH-1:0] rs2,
    output logic                        rs1_pending,
    output logic                        rs2_pending,
    output logic                        rs1_byp,
    output logic                        rs2_byp,
    output logic [DATA_WIDTH-1:0]       rs1_byp_data,
    output logic [DATA_WIDTH-1:0]       rs2_byp_data,
    output logic                        rf_we,
    output logic [ADDRESS_BITWIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0]       rf_wd
);

    localparam int NREGS = 1 << ADDRESS_BITWIDTH;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_entry_t        lsu_entry;
    wb_entry_t        head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic             push;
    logic             pop;
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_next;

    // No same-cycle pop credit: a full FIFO refuses even while draining.
    assign lsu_ready = reset && (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push      = lsu_valid && lsu_ready;
    // ALU has priority; the FIFO drains only in ALU-idle cycles.
    assign pop       = !alu_valid && !fifo_empty;
    assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

    wb_fifo_23rv #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (lsu_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register-file write port. x0 results are still selected (and an x0 FIFO
    // entry is still popped) but never raise rf_we.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rf_we <= 1'b0;
            rf_rd <= '0;
            rf_wd <= '0;
        end else if (alu_valid) begin
            rf_we <= (alu_rd != '0);
            rf_rd <= alu_rd;
            rf_wd <= alu_data;
        end else if (pop) begin
            rf_we <= (head.rd != '0);
            rf_rd <= head.rd;
            rf_wd <= head.data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Scoreboard: the clear is applied before the set so a same-index
    // set/clear in one cycle leaves the bit set. ALU writes never touch it.
    // NOTE: pending_next is given its full default first so no path through
    // this block leaves a bit unassigned, which would infer a latch.
    always_comb begin
        pending_next = pending;
        if (pop)                             pending_next[head.rd]  = 1'b0;
        if (issue_valid && issue_rd != '0)   pending_next[issue_rd] = 1'b1;
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) pending <= '0;
        else        pending <= pending_next;
    end

    assign rs1_pending = pending[rs1];
    assign rs2_pending = pending[rs2];

`ifdef WB_BYPASS_EN
    assign rs1_byp      = rf_we && (rf_rd == rs1) && (rs1 != '0);
    assign rs2_byp      = rf_we && (rf_rd == rs2) && (rs2 != '0);
    assign rs1_byp_data = rf_wd;
    assign rs2_byp_data = rf_wd;
`else
    assign rs1_byp      = 1'b0;
    assign rs2_byp      = 1'b0;
    assign rs1_byp_data = '0;
    assign rs2_byp_data = '0;
`endif

    // Re-issuing to a register that is still pending is a hazard-unit bug.
    a_no_double_issue: assert property (@(posedge clk) disable iff (!reset)
        !(issue_valid && issue_rd != '0 && pending[issue_rd]));

    // The occupancy flags and the count must agree with the ready handshake.
    a_full_blocks_ready: assert property (@(posedge clk) disable iff (!reset)
        fifo_full |-> !lsu_ready);

endmodule

// File: tb/tb_writeback_23rv.sv
// tb_writeback_23rv
// Directed self-checking bench for writeback_23rv. Inputs are driven 1 time
// unit after a rising edge; registered outputs are checked at that point,
// i.e. they reflect the edge just taken.
module tb_writeback_23rv;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_pending;
    logic        rs2_pending;
    logic        rs1_byp;
    logic        rs2_byp;
    logic [31:0] rs1_byp_data;
    logic [31:0] rs2_byp_data;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_23rv dut (
        .clk          (clk),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_pending  (rs1_pending),
        .rs2_pending  (rs2_pending),
        .rs1_byp      (rs1_byp),
        .rs2_byp      (rs2_byp),
        .rs1_byp_data (rs1_byp_data),
        .rs2_byp_data (rs2_byp_data),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_wd        (rf_wd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rf(input string tag, input logic we, input logic [4:0] rd,
                            input logic [31:0] wd);
        check({tag, "_we"}, 32'(rf_we), 32'(we));
        check({tag, "_rd"}, 32'(rf_rd), 32'(rd));
        check({tag, "_wd"}, rf_wd, wd);
    endtask

    initial begin
        reset       = 1'b0;
        alu_valid   = 1'b0;
        alu_rd      = '0;
        alu_data    = '0;
        lsu_valid   = 1'b0;
        lsu_rd      = '0;
        lsu_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        rs1         = '0;
        rs2         = '0;

        // Reset held for two edges, then released.
        tick();
        tick();
        check("ready_in_reset", 32'(lsu_ready), 32'd0);
        reset = 1'b1;
        #1;
        check_rf("reset", 1'b0, 5'd0, 32'h0);
        check("ready_after_reset", 32'(lsu_ready), 32'd1);
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            #1;
            check($sformatf("reset_pend_%0d", i), 32'(rs1_pending), 32'd0);
        end

        // Single ALU write to x5.
        alu_valid = 1'b1;
        alu_rd    = 5'd5;
        alu_data  = 32'hDEAD_BEEF;
        tick();
        alu_valid = 1'b0;
        rs1       = 5'd5;
        rs2       = 5'd0;
        #1;
        check_rf("alu", 1'b1, 5'd5, 32'hDEAD_BEEF);
`ifdef WB_BYPASS_EN
        check("byp1_hit", 32'(rs1_byp), 32'd1);
        check("byp1_data", rs1_byp_data, 32'hDEAD_BEEF);
`else
        check("byp1_off", 32'(rs1_byp), 32'd0);
        check("byp1_data_off", rs1_byp_data, 32'h0);
`endif
        check("byp2_x0", 32'(rs2_byp), 32'd0);
        tick();
        check("alu_idle_we", 32'(rf_we), 32'd0);

        // Long-latency issue to x7, LSU result returns two cycles later.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        tick();
        issue_valid = 1'b0;
        rs1         = 5'd7;
        rs2         = 5'd7;
        #1;
        check("pend7_set", 32'(rs1_pending), 32'd1);
        check("pend7_set_rs2", 32'(rs2_pending), 32'd1);
        tick();
        lsu_valid = 1'b1;
        lsu_rd    = 5'd7;
        lsu_data  = 32'h0000_1234;
        tick();
        lsu_valid = 1'b0;
        check("pend7_accepted", 32'(rs1_pending), 32'd1);
        check("lsu_not_direct_we", 32'(rf_we), 32'd0);
        tick();
        check("pend7_cleared", 32'(rs1_pending), 32'd0);
        check_rf("lsu7", 1'b1, 5'd7, 32'h0000_1234);

        // ALU held four cycles while LSU offers three results.
        alu_valid = 1'b1;
        alu_rd    = 5'd10;
        alu_data  = 32'hA000_0000;
        lsu_valid = 1'b1;
        lsu_rd    = 5'd20;
        lsu_data  = 32'h5000_0000;
        tick();
        check_rf("starve0", 1'b1, 5'd10, 32'hA000_0000);
        check("starve0_ready", 32'(lsu_ready), 32'd1);
        alu_rd   = 5'd11;
        alu_data = 32'hA000_0001;
        lsu_rd   = 5'd21;
        lsu_data = 32'h5000_0001;
        tick();
        check_rf("starve1", 1'b1, 5'd11, 32'hA000_0001);
        check("starve1_ready", 32'(lsu_ready), 32'd0);
        alu_rd   = 5'd12;
        alu_data = 32'hA000_0002;
        lsu_rd   = 5'd22;
        lsu_data = 32'h5000_0002;
        tick();
        check_rf("starve2", 1'b1, 5'd12, 32'hA000_0002);
        check("starve2_ready", 32'(lsu_ready), 32'd0);
        alu_rd   = 5'd13;
        alu_data = 32'hA000_0003;
        tick();
        check_rf("starve3", 1'b1, 5'd13, 32'hA000_0003);
        check("starve3_ready", 32'(lsu_ready), 32'd0);
        alu_valid = 1'b0;
        tick();
        check_rf("drain0", 1'b1, 5'd20, 32'h5000_0000);
        check("drain0_ready", 32'(lsu_ready), 32'd1);
        tick();
        lsu_valid = 1'b0;
        check_rf("drain1", 1'b1, 5'd21, 32'h5000_0001);
        tick();
        check_rf("drain2", 1'b1, 5'd22, 32'h5000_0002);
        tick();
        check("drain_idle_we", 32'(rf_we), 32'd0);

        // Writes to x0 never assert rf_we; the x0 FIFO entry is still popped.
        alu_valid = 1'b1;
        alu_rd    = 5'd0;
        alu_data  = 32'hFFFF_FFFF;
        tick();
        alu_valid = 1'b0;
        check("alu_x0_we", 32'(rf_we), 32'd0);
        lsu_valid = 1'b1;
        lsu_rd    = 5'd0;
        lsu_data  = 32'h0000_ABCD;
        tick();
        lsu_valid = 1'b0;
        tick();
        check_rf("lsu_x0", 1'b0, 5'd0, 32'h0000_ABCD);
        lsu_valid = 1'b1;
        lsu_rd    = 5'd3;
        lsu_data  = 32'h0000_0033;
        tick();
        lsu_valid = 1'b0;
        tick();
        check_rf("after_x0", 1'b1, 5'd3, 32'h0000_0033);

        // Reset with the FIFO full and pending bits set.
        issue_valid = 1'b1;
        issue_rd    = 5'd8;
        tick();
        issue_rd    = 5'd9;
        tick();
        issue_valid = 1'b0;
        alu_valid   = 1'b1;
        alu_rd      = 5'd1;
        alu_data    = 32'h1111_1111;
        lsu_valid   = 1'b1;
        lsu_rd      = 5'd8;
        lsu_data    = 32'h8888_8888;
        tick();
        lsu_rd      = 5'd9;
        lsu_data    = 32'h9999_9999;
        tick();
        rs1 = 5'd8;
        rs2 = 5'd9;
        #1;
        check("pre_rst_full", 32'(lsu_ready), 32'd0);
        check("pre_rst_pend8", 32'(rs1_pending), 32'd1);
        check("pre_rst_pend9", 32'(rs2_pending), 32'd1);
        reset     = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        tick();
        check_rf("mid_rst", 1'b0, 5'd0, 32'h0);
        check("mid_rst_ready", 32'(lsu_ready), 32'd0);
        check("mid_rst_pend8", 32'(rs1_pending), 32'd0);
        check("mid_rst_pend9", 32'(rs2_pending), 32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", 32'(lsu_ready), 32'd1);
        tick();
        check("post_rst_we0", 32'(rf_we), 32'd0);
        tick();
        check("post_rst_we1", 32'(rf_we), 32'd0);
        check("post_rst_wd", rf_wd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
